// File: rtl/mem_access_unit.sv
// mem_access_unit: req/ready sequencer for async SRAM and one memory-mapped IO word, with configurable wait states.
// Optional byte enables when MEM_BYTE_LANE_EN is defined (requires DATA_W==16).
module mem_access_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR = 20'h0FFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_BYTE_LANE_EN
  input  logic [1:0]        be,
`endif
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] hex_out,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              data_oe,
  input  logic [DATA_W-1:0] Data_from_SRAM
);
  typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] be_q, be_d, be_in;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, hex_q, hex_d, rd_word;
  logic ce_q, ce_d, oe_q, oe_d, wen_q, wen_d, ub_q, ub_d, lb_q, lb_d;
  logic doe_q, doe_d, ready_q, ready_d, busy_q, busy_d, acc, en;
`ifdef MEM_BYTE_LANE_EN
  assign be_in = be;
  assign rd_word = be_q == 2'b01 ? {{(DATA_W-8){1'b0}}, Data_from_SRAM[7:0]} :
                   be_q == 2'b10 ? {{(DATA_W-8){1'b0}}, Data_from_SRAM[15:8]} : Data_from_SRAM;
`else
  assign be_in = 2'b11;
  assign rd_word = Data_from_SRAM;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    rdata_d = rdata_q;
    hex_d = hex_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d = addr;
        wdata_d = wdata;
        be_d = be_in;
        if (addr == IO_ADDR) begin
          state_d = DONE;
          rdata_d = we ? rdata_q : Switches;
          hex_d = we ? wdata : hex_q;
        end else begin
          state_d = we ? WR : RD;
          cnt_d = we ? 4'(WR_WAIT) : 4'(RD_WAIT);
        end
      end
      RD: begin
        cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? DONE : RD;
        rdata_d = cnt_q == 4'd0 && |be_q ? rd_word : rdata_q;
      end
      WR: begin
        cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? WR_HOLD : WR;
      end
      WR_HOLD: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes decode the next state so they come straight off flops; be==0 runs the timing with no strobes
    acc = state_d inside {RD, WR, WR_HOLD};
    en = acc && |be_d;
    ce_d = ~en;
    oe_d = ~(en && state_d == RD);
    wen_d = ~(en && state_d == WR);
    ub_d = ~(en && be_d[1]);
    lb_d = ~(en && be_d[0]);
    doe_d = en && state_d != RD;
    ready_d = state_d == DONE;
    busy_d = acc;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= 2'b11;
      rdata_q <= '0;
      hex_q <= '0;
      ce_q <= 1'b1;
      oe_q <= 1'b1;
      wen_q <= 1'b1;
      ub_q <= 1'b1;
      lb_q <= 1'b1;
      doe_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rdata_q <= rdata_d;
      hex_q <= hex_d;
      ce_q <= ce_d;
      oe_q <= oe_d;
      wen_q <= wen_d;
      ub_q <= ub_d;
      lb_q <= lb_d;
      doe_q <= doe_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  end
  assign ready = ready_q;
  assign busy = busy_q;
  assign rdata = rdata_q;
  assign hex_out = hex_q;
  assign CE = ce_q;
  assign OE = oe_q;
  assign WE = wen_q;
  assign UB = ub_q;
  assign LB = lb_q;
  assign ADDR = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign data_oe = doe_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors against a default-wait instance and a zero-wait instance.
module tb_mem_access_unit;
  logic Clk = 0, Reset = 1, req = 0, req0 = 0, we = 0, sel = 0;
  logic [19:0] addr = '0;
  logic [15:0] wdata = '0, Switches = '0, Data_from_SRAM = '0;
`ifdef MEM_BYTE_LANE_EN
  logic [1:0] be = 2'b11;
`endif
  logic d_ready, d_busy, d_ce, d_oe, d_we, d_ub, d_lb, d_doe;
  logic z_ready, z_busy, z_ce, z_oe, z_we, z_ub, z_lb, z_doe;
  logic [15:0] d_rdata, d_hex, d_dts, z_rdata, z_hex, z_dts;
  logic [19:0] d_addr, z_addr;
  logic m_ready, m_busy, m_ce, m_oe, m_we, m_doe;
  logic [15:0] m_rdata, m_hex, m_dts;
  logic [19:0] m_addr;
  int n_chk = 0, n_fail = 0;

  always #5 Clk = ~Clk;

  mem_access_unit u_dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_LANE_EN
    .be(be),
`endif
    .ready(d_ready), .busy(d_busy), .rdata(d_rdata), .Switches(Switches), .hex_out(d_hex),
    .CE(d_ce), .OE(d_oe), .WE(d_we), .UB(d_ub), .LB(d_lb), .ADDR(d_addr),
    .Data_to_SRAM(d_dts), .data_oe(d_doe), .Data_from_SRAM(Data_from_SRAM));

  mem_access_unit #(.RD_WAIT(0), .WR_WAIT(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .req(req0), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_LANE_EN
    .be(be),
`endif
    .ready(z_ready), .busy(z_busy), .rdata(z_rdata), .Switches(Switches), .hex_out(z_hex),
    .CE(z_ce), .OE(z_oe), .WE(z_we), .UB(z_ub), .LB(z_lb), .ADDR(z_addr),
    .Data_to_SRAM(z_dts), .data_oe(z_doe), .Data_from_SRAM(Data_from_SRAM));

  assign m_ready = sel ? z_ready : d_ready;
  assign m_busy = sel ? z_busy : d_busy;
  assign m_ce = sel ? z_ce : d_ce;
  assign m_oe = sel ? z_oe : d_oe;
  assign m_we = sel ? z_we : d_we;
  assign m_doe = sel ? z_doe : d_doe;
  assign m_rdata = sel ? z_rdata : d_rdata;
  assign m_hex = sel ? z_hex : d_hex;
  assign m_dts = sel ? z_dts : d_dts;
  assign m_addr = sel ? z_addr : d_addr;

  typedef struct {
    logic sel, w;
    logic [19:0] a;
    logic [15:0] wd, sw, dfs;
    int lat, ce, oe, wen, hold;
    logic [15:0] rd, hx;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input int k, input vec_t v);
    int lat, ce_n, oe_n, we_n, hold_n, busy_n, dts_bad;
    string p;
    p = $sformatf("v%0d", k);
    ce_n = 0; oe_n = 0; we_n = 0; hold_n = 0; busy_n = 0; dts_bad = 0;
    @(negedge Clk);
    sel = v.sel; we = v.w; addr = v.a; wdata = v.wd; Switches = v.sw; Data_from_SRAM = v.dfs;
    if (v.sel) req0 = 1; else req = 1;
    @(negedge Clk);
    req = 0; req0 = 0; we = ~v.w; addr = ~v.a; wdata = ~v.wd;
    lat = 1;
    while (!m_ready && lat < 40) begin
      ce_n += int'(!m_ce);
      oe_n += int'(!m_oe);
      we_n += int'(!m_we);
      hold_n += int'(!m_ce && m_we && m_oe && m_doe);
      busy_n += int'(m_busy);
      if (m_doe && m_dts !== v.wd) dts_bad++;
      @(negedge Clk);
      lat++;
    end
    chk({p, " latency"}, lat, v.lat);
    chk({p, " ce_low"}, ce_n, v.ce);
    chk({p, " oe_low"}, oe_n, v.oe);
    chk({p, " we_low"}, we_n, v.wen);
    chk({p, " hold"}, hold_n, v.hold);
    chk({p, " busy_cycles"}, busy_n, v.a == 20'h0FFFF ? 0 : v.lat - 1);
    chk({p, " wdata_stable"}, dts_bad, 0);
    chk({p, " busy_at_ready"}, m_busy, 0);
    chk({p, " rdata"}, m_rdata, v.rd);
    chk({p, " hex_out"}, m_hex, v.hx);
    chk({p, " ADDR"}, m_addr, v.a);
    chk({p, " Data_to_SRAM"}, m_dts, v.wd);
  endtask

  initial begin
    int rdy_seen;
    tv[0] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h0000, 16'hBEEF, 4, 3, 3, 0, 0, 16'hBEEF, 16'h0000};
    tv[1] = '{1'b0, 1'b1, 20'h00020, 16'h1234, 16'h0000, 16'h0000, 5, 4, 0, 3, 1, 16'hBEEF, 16'h0000};
    tv[2] = '{1'b0, 1'b0, 20'h0FFFF, 16'h0000, 16'h00A5, 16'h0000, 1, 0, 0, 0, 0, 16'h00A5, 16'h0000};
    tv[3] = '{1'b0, 1'b1, 20'h0FFFF, 16'h0C3F, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h00A5, 16'h0C3F};
    tv[4] = '{1'b0, 1'b0, 20'h12345, 16'h0000, 16'h0000, 16'h5A5A, 4, 3, 3, 0, 0, 16'h5A5A, 16'h0C3F};
    tv[5] = '{1'b0, 1'b1, 20'hFFFFE, 16'hFFFF, 16'h0000, 16'h1111, 5, 4, 0, 3, 1, 16'h5A5A, 16'h0C3F};
    tv[6] = '{1'b1, 1'b0, 20'h00030, 16'h0000, 16'h0000, 16'h1357, 2, 1, 1, 0, 0, 16'h1357, 16'h0000};
    tv[7] = '{1'b1, 1'b1, 20'h00040, 16'h2468, 16'h0000, 16'h0000, 3, 2, 0, 1, 1, 16'h1357, 16'h0000};
    tv[8] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h0000, 16'hBEEF, 4, 3, 3, 0, 0, 16'hBEEF, 16'h0000};

    @(negedge Clk);
    chk("reset strobes", {d_ce, d_oe, d_we, d_ub, d_lb}, 5'b11111);
    chk("reset ctl", {d_ready, d_busy, d_doe}, 3'b000);
    chk("reset rdata", d_rdata, 0);
    chk("reset hex", d_hex, 0);
    chk("reset ADDR", d_addr, 0);
    chk("reset Data_to_SRAM", d_dts, 0);
    Reset = 0;

    for (int k = 0; k < 8; k++) run(k, tv[k]);

    sel = 0;
    @(negedge Clk);
    req = 1; we = 0; addr = 20'h00010; Data_from_SRAM = 16'hBEEF;
    @(negedge Clk);
    req = 0;
    @(negedge Clk);
    chk("midrd in access", {d_ce, d_oe, d_we, d_ub, d_lb, d_busy}, 6'b001001);
    #2 Reset = 1;
    #1;
    chk("midrd reset strobes", {d_ce, d_oe, d_we}, 3'b111);
    chk("midrd reset busy", d_busy, 0);
    chk("midrd reset rdata", d_rdata, 0);
    @(negedge Clk);
    Reset = 0;
    run(8, tv[8]);

    rdy_seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (i >= 1) begin
        chk($sformatf("reqhold ready e%0d", i - 1), d_ready, ((i - 1) % 5) == 3);
        if (d_ready) chk($sformatf("reqhold ADDR e%0d", i - 1), d_addr, 20'h00100 + 20'(i - 4));
      end
      req = 1; we = 0; addr = 20'h00100 + 20'(i);
    end
    @(negedge Clk);
    req = 0;
    for (int i = 0; i < 10 && rdy_seen == 0; i++) begin
      if (d_ready) rdy_seen = 1; else @(negedge Clk);
    end
    chk("reqhold drain ready", rdy_seen, 1);
    chk("reqhold drain ADDR", d_addr, 20'h0010F);

`ifdef MEM_BYTE_LANE_EN
    @(negedge Clk);
    req = 1; we = 0; addr = 20'h00050; be = 2'b10; Data_from_SRAM = 16'hBEEF;
    @(negedge Clk);
    req = 0; be = 2'b11;
    chk("be10 lanes", {d_ce, d_ub, d_lb}, 3'b001);
    rdy_seen = 0;
    for (int i = 0; i < 10 && rdy_seen == 0; i++) begin
      if (d_ready) rdy_seen = 1; else @(negedge Clk);
    end
    chk("be10 ready", rdy_seen, 1);
    chk("be10 rdata", d_rdata, 16'h00BE);
`endif

    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
